// File: rtl/uart_rx_deframer_pkg.sv
// Shared definitions for the UART receive deframer: state encodings,
// frame constants and the 3-sample majority vote.
package uart_rx_deframer_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam int DATA_BITS            = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_deframer_if.sv
// Byte-side handshake of the UART receiver: holding register, valid/ready,
// error pulses and busy status.
interface uart_rx_deframer_if;
  import uart_rx_deframer_pkg::*;

  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  modport master (output data, valid, frame_err, overrun, busy, input ready);
  modport slave  (input data, valid, frame_err, overrun, busy, output ready);
endinterface

// File: rtl/uart_rx_deframer_sync_2ff.sv
// Two-flop synchroniser with a parameterised reset value, for asynchronous
// input pins.
module uart_rx_deframer_sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_deframer.sv
// 8N1 UART receiver: synchronised line, majority-voted mid-bit sampling,
// one-byte holding register with framing-error and overrun pulses.
module uart_rx_deframer
  import uart_rx_deframer_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rxd,
  uart_rx_deframer_if.master rx
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int BIT_W    = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] SAMP_A   = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] SAMP_B   = CNT_W'(HALF_BIT);
  localparam logic [CNT_W-1:0] SAMP_C   = CNT_W'(HALF_BIT + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  logic                 rxs;
  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 samp_a_q, samp_a_d, samp_b_q, samp_b_d;
  logic                 vote, deliver, frame_err_d;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, frame_err_q, overrun_q;

  uart_rx_deframer_sync_2ff #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync_2ff (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rxd),
    .q     (rxs)
  );

  assign vote = majority3(samp_a_q, samp_b_q, rxs);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      samp_a_q <= 1'b1;
      samp_b_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      samp_a_q <= samp_a_d;
      samp_b_q <= samp_b_d;
    end
  end

  // The bit decision is taken at the third sample point using the two stored
  // samples plus the live line; STOP returns to IDLE there for early re-arm.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    samp_a_d    = samp_a_q;
    samp_b_d    = samp_b_q;
    deliver     = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rxs) begin
          cnt_d   = '0;
          state_d = ST_START;
        end
      end
      ST_BREAK: begin
        if (rxs) state_d = ST_IDLE;
      end
      default: begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        if (cnt_q == SAMP_A) samp_a_d = rxs;
        if (cnt_q == SAMP_B) samp_b_d = rxs;
        if (cnt_q == SAMP_C) begin
          if (state_q == ST_START) begin
            state_d = vote ? ST_IDLE : ST_DATA;
            bit_d   = '0;
          end else if (state_q == ST_DATA) begin
            shift_d = {vote, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + 1'b1;
            if (bit_q == BIT_LAST) state_d = ST_STOP;
          end else begin
            state_d     = vote ? ST_IDLE : ST_BREAK;
            deliver     = vote;
            frame_err_d = !vote;
          end
        end
      end
    endcase
  end

  // A byte that arrives while the register is full is only accepted if the
  // consumer takes the old one in that same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
      overrun_q   <= 1'b0;
      if (deliver) begin
        if (!valid_q || rx.ready) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && rx.ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx.data      = data_q;
  assign rx.valid     = valid_q;
  assign rx.frame_err = frame_err_q;
  assign rx.overrun   = overrun_q;
  assign rx.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Self-checking bench for uart_rx_deframer at 16 clocks per bit; received
// bytes are scored against a queue of expected bytes.
module tb_uart_rx_deframer;
  import uart_rx_deframer_pkg::*;

  localparam int CPB = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rxd   = 1'b1;

  uart_rx_deframer_if rx_if ();

  uart_rx_deframer #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rxd   (rxd),
    .rx    (rx_if.master)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int start_cyc = 0;

  always @(posedge clk) cyc++;

  // Monitor: counts flag pulses and valid cycles, and records every byte the
  // DUT loads into its holding register.
  int   n_fe = 0, n_ov = 0, n_vcyc = 0, last_rise_cyc = 0;
  logic prev_valid = 1'b0, prev_hs = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int   got_rd = 0, exp_rd = 0;

  always @(negedge clk) begin
    if (rx_if.frame_err) n_fe++;
    if (rx_if.overrun) n_ov++;
    if (rx_if.valid) n_vcyc++;
    if (rx_if.valid && (!prev_valid || prev_hs)) begin
      got_q.push_back(rx_if.data);
      if (!prev_valid) last_rise_cyc = cyc;
    end
    prev_valid = rx_if.valid;
    prev_hs    = rx_if.valid && rx_if.ready;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One 8N1 frame; stop_low_bits>0 holds the stop bit low that many bit
  // times, glitch_at inverts one cycle, pulse_at raises ready for one cycle.
  task automatic send_frame(input logic [7:0] b, input int stop_low_bits,
                            input int glitch_at, input int pulse_at,
                            input logic ready_base);
    int   ncyc;
    int   fb;
    logic v;
    ncyc = 9 * CPB + ((stop_low_bits > 0) ? stop_low_bits * CPB : CPB);
    @(posedge clk);
    for (int c = 0; c < ncyc; c++) begin
      #1;
      if (c == 0) start_cyc = cyc;
      fb = c / CPB;
      if (fb == 0) v = 1'b0;
      else if (fb <= 8) v = b[fb-1];
      else v = (stop_low_bits == 0);
      rxd = v ^ (c == glitch_at);
      rx_if.ready = (c == pulse_at) ? 1'b1 : ready_base;
      @(posedge clk);
    end
  endtask

  task automatic score(input string name);
    while (exp_rd < exp_q.size()) begin
      checks++;
      if (got_rd >= got_q.size()) begin
        errors++;
        $display("[TB] FAIL %s_byte: got none expected %02h", name, exp_q[exp_rd]);
      end else begin
        if (got_q[got_rd] !== exp_q[exp_rd]) begin
          errors++;
          $display("[TB] FAIL %s_byte: got %02h expected %02h", name, got_q[got_rd], exp_q[exp_rd]);
        end
        got_rd++;
      end
      exp_rd++;
    end
    checks++;
    if (got_rd != got_q.size()) begin
      errors++;
      $display("[TB] FAIL %s_extra: got %0d unexpected bytes expected 0", name, got_q.size() - got_rd);
      got_rd = got_q.size();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rxd = 1'b1;
    rx_if.ready = 1'b0;
    idle(3);
    checks += 5;
    if (rx_if.data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got %02h expected 00", rx_if.data); end
    if (rx_if.valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", rx_if.valid); end
    if (rx_if.frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_err: got %b expected 0", rx_if.frame_err); end
    if (rx_if.overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %b expected 0", rx_if.overrun); end
    if (rx_if.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", rx_if.busy); end
    rst_n = 1'b1;
    idle(5);
  endtask

  task automatic test_basic();
    int fe0, ov0, v0, lat;
    fe0 = n_fe; ov0 = n_ov; v0 = n_vcyc;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 0, -1, -1, 1'b1);
    idle(4);
    score("basic");
    lat = last_rise_cyc - start_cyc - 1;
    checks += 4;
    if (lat < 154 || lat > 156) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected 155+-1", lat); end
    if (n_vcyc - v0 != 1) begin errors++; $display("[TB] FAIL basic_valid_cycles: got %0d expected 1", n_vcyc - v0); end
    if (n_fe != fe0) begin errors++; $display("[TB] FAIL basic_frame_err: got %0d expected 0", n_fe - fe0); end
    if (n_ov != ov0) begin errors++; $display("[TB] FAIL basic_overrun: got %0d expected 0", n_ov - ov0); end
  endtask

  task automatic test_start_glitch();
    int fe0, ov0;
    fe0 = n_fe; ov0 = n_ov;
    @(posedge clk); #1;
    rxd = 1'b0;
    idle(4);
    rxd = 1'b1;
    idle(2);
    checks++;
    if (rx_if.busy !== 1'b1) begin errors++; $display("[TB] FAIL glitch_busy_start: got %b expected 1", rx_if.busy); end
    idle(30);
    checks += 3;
    if (rx_if.busy !== 1'b0) begin errors++; $display("[TB] FAIL glitch_busy_idle: got %b expected 0", rx_if.busy); end
    if (n_fe != fe0) begin errors++; $display("[TB] FAIL glitch_frame_err: got %0d expected 0", n_fe - fe0); end
    if (n_ov != ov0) begin errors++; $display("[TB] FAIL glitch_overrun: got %0d expected 0", n_ov - ov0); end
    score("glitch");
  endtask

  task automatic test_frame_error();
    int fe0, ov0;
    fe0 = n_fe; ov0 = n_ov;
    send_frame(8'h3C, 3, -1, -1, 1'b1);
    #1;
    checks++;
    if (rx_if.busy !== 1'b1) begin errors++; $display("[TB] FAIL ferr_busy_break: got %b expected 1", rx_if.busy); end
    rxd = 1'b1;
    idle(6);
    checks += 3;
    if (rx_if.busy !== 1'b0) begin errors++; $display("[TB] FAIL ferr_busy_after: got %b expected 0", rx_if.busy); end
    if (n_fe - fe0 != 1) begin errors++; $display("[TB] FAIL ferr_pulses: got %0d expected 1", n_fe - fe0); end
    if (n_ov != ov0) begin errors++; $display("[TB] FAIL ferr_overrun: got %0d expected 0", n_ov - ov0); end
    score("ferr");
  endtask

  task automatic test_data_glitch();
    int fe0, ov0;
    fe0 = n_fe; ov0 = n_ov;
    exp_q.push_back(8'h00);
    send_frame(8'h00, 0, 4 * CPB + 9, -1, 1'b1);
    idle(4);
    score("vote");
    checks += 2;
    if (n_fe != fe0) begin errors++; $display("[TB] FAIL vote_frame_err: got %0d expected 0", n_fe - fe0); end
    if (n_ov != ov0) begin errors++; $display("[TB] FAIL vote_overrun: got %0d expected 0", n_ov - ov0); end
  endtask

  task automatic test_overrun();
    int fe0, ov0;
    fe0 = n_fe; ov0 = n_ov;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 0, -1, -1, 1'b0);
    send_frame(8'h22, 0, -1, -1, 1'b0);
    idle(4);
    score("ovr");
    checks += 4;
    if (n_ov - ov0 != 1) begin errors++; $display("[TB] FAIL ovr_pulses: got %0d expected 1", n_ov - ov0); end
    if (n_fe != fe0) begin errors++; $display("[TB] FAIL ovr_frame_err: got %0d expected 0", n_fe - fe0); end
    if (rx_if.data !== 8'h11) begin errors++; $display("[TB] FAIL ovr_data_held: got %02h expected 11", rx_if.data); end
    if (rx_if.valid !== 1'b1) begin errors++; $display("[TB] FAIL ovr_valid_held: got %b expected 1", rx_if.valid); end
    rx_if.ready = 1'b1;
    idle(1);
    rx_if.ready = 1'b0;
    idle(2);
    checks++;
    if (rx_if.valid !== 1'b0) begin errors++; $display("[TB] FAIL ovr_drain: got %b expected 0", rx_if.valid); end
  endtask

  task automatic test_back_to_back();
    int ov0;
    ov0 = n_ov;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_frame(8'h11, 0, -1, -1, 1'b0);
    send_frame(8'h22, 0, -1, 156, 1'b0);
    idle(3);
    score("b2b");
    checks += 3;
    if (rx_if.data !== 8'h22) begin errors++; $display("[TB] FAIL b2b_data: got %02h expected 22", rx_if.data); end
    if (rx_if.valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid: got %b expected 1", rx_if.valid); end
    if (n_ov != ov0) begin errors++; $display("[TB] FAIL b2b_overrun: got %0d expected 0", n_ov - ov0); end
    rx_if.ready = 1'b1;
    idle(1);
    rx_if.ready = 1'b0;
    idle(2);
  endtask

  task automatic test_mid_reset();
    logic [7:0] b;
    b = 8'h77;
    @(posedge clk);
    for (int c = 0; c < 5 * CPB + 8; c++) begin
      #1;
      rxd = (c < CPB) ? 1'b0 : b[c/CPB-1];
      @(posedge clk);
    end
    #1;
    checks++;
    if (rx_if.busy !== 1'b1) begin errors++; $display("[TB] FAIL mreset_busy_before: got %b expected 1", rx_if.busy); end
    #2;
    rst_n = 1'b0;
    rxd = 1'b1;
    #1;
    checks += 5;
    if (rx_if.data !== 8'h00) begin errors++; $display("[TB] FAIL mreset_data: got %02h expected 00", rx_if.data); end
    if (rx_if.valid !== 1'b0) begin errors++; $display("[TB] FAIL mreset_valid: got %b expected 0", rx_if.valid); end
    if (rx_if.busy !== 1'b0) begin errors++; $display("[TB] FAIL mreset_busy: got %b expected 0", rx_if.busy); end
    if (rx_if.frame_err !== 1'b0) begin errors++; $display("[TB] FAIL mreset_frame_err: got %b expected 0", rx_if.frame_err); end
    if (rx_if.overrun !== 1'b0) begin errors++; $display("[TB] FAIL mreset_overrun: got %b expected 0", rx_if.overrun); end
    idle(3);
    rst_n = 1'b1;
    idle(5);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 0, -1, -1, 1'b1);
    idle(4);
    score("mreset");
  endtask

  initial begin
    rx_if.ready = 1'b0;
    test_reset();
    test_basic();
    test_start_glitch();
    test_frame_error();
    test_data_glitch();
    test_overrun();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
